// File: rtl/round_sequencer.sv
// round_sequencer: drives a countdown timer through a fixed number of game
// rounds. It re-arms the timer before each round, enables it while the round
// runs, and inserts a timed break between rounds. It also flags the low-time
// warning and game over.
module round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 3,          // rounds per game, 1..15
    parameter int unsigned BREAK_CYC  = 100000000,  // break length in clk cycles, 0 acts as 1
    parameter int unsigned WARN_SEC   = 10          // warn while seconds <= this
) (
    input  logic       i_clk,
    input  logic       i_rst_n,        // asynchronous, active-low
    input  logic       i_start,        // one-cycle pulse: begin a game
    input  logic       i_abort,        // one-cycle pulse: cancel the game
    input  logic       i_tmr_done,     // timer done flag (sticky level)
    input  logic [7:0] i_tmr_t,        // timer seconds remaining
    output logic       o_tmr_en,       // timer enable, high only in RUN
    output logic       o_tmr_rst_n,    // timer reset, low in IDLE and ARM
    output logic [3:0] o_round_num,    // 1..NUM_ROUNDS, 0 when idle
    output logic       o_round_done,   // one-cycle pulse when a round expires
    output logic       o_warn,         // low-time warning during RUN
    output logic       o_game_over     // high in OVER
);

    // The last break-counter value. A zero break length behaves like one cycle.
    localparam logic [31:0] BREAK_LAST = (BREAK_CYC == 0) ? 32'd0 : BREAK_CYC - 32'd1;
    localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0]  WARN_T     = 8'(WARN_SEC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_BREAK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_round;
    logic [3:0]  w_round_next;
    logic [31:0] r_brk_cnt;
    logic [31:0] w_brk_cnt_next;
    logic        w_round_done_next;

    logic        r_tmr_en;
    logic        r_tmr_rst_n;
    logic        r_round_done;
    logic        r_warn;
    logic        r_game_over;

    // Next-state, round and break-counter logic. An abort wins over every other event.
    always_comb begin
        w_state_next      = r_state;
        w_round_next      = r_round;
        w_brk_cnt_next    = r_brk_cnt;
        w_round_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_next = S_ARM;
                    w_round_next = 4'd1;
                end
            end
            S_ARM: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                    w_round_next = 4'd0;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                    w_round_next = 4'd0;
                end else if (i_tmr_done) begin
                    w_round_done_next = 1'b1;
                    if (r_round >= LAST_ROUND) begin
                        w_state_next = S_OVER;
                    end else begin
                        w_state_next   = S_BREAK;
                        w_brk_cnt_next = 32'd0;
                    end
                end
            end
            S_BREAK: begin
                if (i_abort) begin
                    w_state_next   = S_IDLE;
                    w_round_next   = 4'd0;
                    w_brk_cnt_next = 32'd0;
                end else if (r_brk_cnt == BREAK_LAST) begin
                    w_state_next   = S_ARM;
                    w_round_next   = r_round + 4'd1;
                    w_brk_cnt_next = 32'd0;
                end else begin
                    w_brk_cnt_next = r_brk_cnt + 32'd1;
                end
            end
            S_OVER: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                    w_round_next = 4'd0;
                end else if (i_start) begin
                    w_state_next = S_ARM;
                    w_round_next = 4'd1;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_round_next   = 4'd0;
                w_brk_cnt_next = 32'd0;
            end
        endcase
    end

    // State, counters and registered outputs. The timer controls are decoded from
    // the next state, so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_round      <= 4'd0;
            r_brk_cnt    <= 32'd0;
            r_tmr_en     <= 1'b0;
            r_tmr_rst_n  <= 1'b0;
            r_round_done <= 1'b0;
            r_warn       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_round      <= w_round_next;
            r_brk_cnt    <= w_brk_cnt_next;
            r_tmr_en     <= (w_state_next == S_RUN);
            r_tmr_rst_n  <= !((w_state_next == S_IDLE) || (w_state_next == S_ARM));
            r_round_done <= w_round_done_next;
            r_warn       <= (r_state == S_RUN) && (i_tmr_t <= WARN_T);
            r_game_over  <= (w_state_next == S_OVER);
        end
    end

    assign o_tmr_en     = r_tmr_en;
    assign o_tmr_rst_n  = r_tmr_rst_n;
    assign o_round_num  = r_round;
    assign o_round_done = r_round_done;
    assign o_warn       = r_warn;
    assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer: table-driven vectors through an expected-value
// queue, then whole-game, reset and abort sequences against a behavioural timer.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       v_done = 1'b0;
    logic [7:0] v_t = 8'd60;
    logic       use_model = 1'b0;
    logic       tmr_done;
    logic [7:0] tmr_t;
    logic       tmr_en, tmr_rst_n, round_done, warn, game_over;
    logic [3:0] round_num;

    int checks = 0;
    int failures = 0;

    round_sequencer #(.NUM_ROUNDS(2), .BREAK_CYC(4), .WARN_SEC(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_tmr_done(tmr_done), .i_tmr_t(tmr_t),
        .o_tmr_en(tmr_en), .o_tmr_rst_n(tmr_rst_n), .o_round_num(round_num),
        .o_round_done(round_done), .o_warn(warn), .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    // Behavioural 60 s timer, 1 s = 8 clocks.
    logic [7:0] m_t;
    logic       m_done;
    logic [2:0] m_pre;
    always @(posedge clk or negedge tmr_rst_n) begin
        if (!tmr_rst_n) begin
            m_t <= 8'd60; m_done <= 1'b0; m_pre <= 3'd0;
        end else if (tmr_en && !m_done) begin
            if (m_pre == 3'd7) begin
                m_pre <= 3'd0;
                if (m_t == 8'd1) begin m_t <= 8'd0; m_done <= 1'b1; end
                else m_t <= m_t - 8'd1;
            end else begin
                m_pre <= m_pre + 3'd1;
            end
        end
    end

    assign tmr_done = use_model ? m_done : v_done;
    assign tmr_t    = use_model ? m_t : v_t;

    typedef struct {
        logic       start, abort, done;
        logic [7:0] t;
        logic       en, rstn;
        logic [3:0] rnd;
        logic       rd, warn, go;
    } vec_t;

    vec_t vecs[21];
    vec_t exp_q[$];
    int   rnd_q[$];

    function automatic vec_t mk(int s, int a, int d, int t, int en, int rn, int r, int rd, int w, int g);
        vec_t v;
        v.start = (s != 0); v.abort = (a != 0); v.done = (d != 0); v.t = 8'(t);
        v.en = (en != 0); v.rstn = (rn != 0); v.rnd = 4'(r);
        v.rd = (rd != 0); v.warn = (w != 0); v.go = (g != 0);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic en, logic rstn, logic [3:0] rnd, logic rd, logic w, logic go);
        check({tag, ".tmr_en"},     32'(tmr_en),     32'(en));
        check({tag, ".tmr_rst_n"},  32'(tmr_rst_n),  32'(rstn));
        check({tag, ".round_num"},  32'(round_num),  32'(rnd));
        check({tag, ".round_done"}, 32'(round_done), 32'(rd));
        check({tag, ".warn"},       32'(warn),       32'(w));
        check({tag, ".game_over"},  32'(game_over),  32'(go));
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        int   pulses, breaks, brk_len, cyc;
        logic exp_warn_nxt, seen_warn;

        // columns: start abort done t | en rst_n round round_done warn game_over
        vecs[0]  = mk(1,0,0,60, 0,0,1,0,0,0);  // start -> ARM
        vecs[1]  = mk(0,0,0,60, 1,1,1,0,0,0);  // ARM -> RUN
        vecs[2]  = mk(0,0,0,10, 1,1,1,0,1,0);  // t==10 warns
        vecs[3]  = mk(0,0,0,11, 1,1,1,0,0,0);  // t==11 does not
        vecs[4]  = mk(1,0,0, 9, 1,1,1,0,1,0);  // start in RUN ignored
        vecs[5]  = mk(0,0,1, 0, 0,1,1,1,1,0);  // done -> BREAK, pulse, warn lags
        vecs[6]  = mk(0,0,1, 0, 0,1,1,0,0,0);  // BREAK 2
        vecs[7]  = mk(1,0,1, 0, 0,1,1,0,0,0);  // BREAK 3, start ignored
        vecs[8]  = mk(0,0,1, 0, 0,1,1,0,0,0);  // BREAK 4
        vecs[9]  = mk(0,0,1, 0, 0,0,2,0,0,0);  // ARM round 2
        vecs[10] = mk(0,0,0,60, 1,1,2,0,0,0);  // RUN round 2
        vecs[11] = mk(0,0,1, 0, 0,1,2,1,1,1);  // last round -> OVER
        vecs[12] = mk(0,0,1, 0, 0,1,2,0,0,1);  // OVER holds
        vecs[13] = mk(1,0,1, 0, 0,0,1,0,0,0);  // restart from OVER
        vecs[14] = mk(0,0,0,60, 1,1,1,0,0,0);  // RUN
        vecs[15] = mk(0,1,1,60, 0,0,0,0,0,0);  // abort beats done
        vecs[16] = mk(1,1,0,60, 0,0,0,0,0,0);  // abort beats start in IDLE
        vecs[17] = mk(1,0,0,60, 0,0,1,0,0,0);  // ARM
        vecs[18] = mk(0,0,0,60, 1,1,1,0,0,0);  // RUN
        vecs[19] = mk(0,0,1,60, 0,1,1,1,0,0);  // BREAK
        vecs[20] = mk(0,1,0,60, 0,0,0,0,0,0);  // abort in BREAK

        // Reset state
        step(); step();
        check_outs("reset", 0, 0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_outs("idle", 0, 0, 4'd0, 0, 0, 0);

        // Table vectors through the expected-value queue
        foreach (vecs[i]) begin
            start = vecs[i].start; abort = vecs[i].abort;
            v_done = vecs[i].done; v_t = vecs[i].t;
            exp_q.push_back(vecs[i]);
            step();
            e = exp_q.pop_front();
            check_outs($sformatf("vec%0d", i), e.en, e.rstn, e.rnd, e.rd, e.warn, e.go);
            $display("vec %0d: en=%0d rst_n=%0d round=%0d rd=%0d warn=%0d go=%0d",
                     i, tmr_en, tmr_rst_n, round_num, round_done, warn, game_over);
        end
        start = 1'b0; abort = 1'b0; v_done = 1'b0;

        // Full game against the timer model
        use_model = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        check("game.arm_rst_n", 32'(tmr_rst_n), 32'd0);
        check("game.arm_en", 32'(tmr_en), 32'd0);
        check("game.arm_round", 32'(round_num), 32'd1);
        step();
        check("game.run_en", 32'(tmr_en), 32'd1);
        check("game.run_rst_n", 32'(tmr_rst_n), 32'd1);
        rnd_q.push_back(1); rnd_q.push_back(2);
        pulses = 0; breaks = 0; brk_len = 0; cyc = 0; seen_warn = 1'b0;
        exp_warn_nxt = tmr_en && (tmr_t <= 8'd10);
        while (!game_over && cyc < 3000) begin
            step(); cyc++;
            check("game.warn", 32'(warn), 32'(exp_warn_nxt));
            if (warn) seen_warn = 1'b1;
            exp_warn_nxt = tmr_en && (tmr_t <= 8'd10);
            if (round_done) begin
                pulses++;
                if (rnd_q.size() == 0) check("game.extra_round_done", 32'(round_num), 32'd0);
                else check("game.round_at_done", 32'(round_num), 32'(rnd_q.pop_front()));
                $display("round_done: round=%0d cycle=%0d", round_num, cyc);
            end
            if (!tmr_en && tmr_rst_n && !game_over) brk_len++;
            else if (brk_len != 0) begin
                breaks++;
                check("game.break_len", 32'(brk_len), 32'd4);
                brk_len = 0;
            end
        end
        check("game.reached_over", 32'(game_over), 32'd1);
        check("game.final_round", 32'(round_num), 32'd2);
        check("game.over_en", 32'(tmr_en), 32'd0);
        check("game.pulses", 32'(pulses), 32'd2);
        check("game.breaks", 32'(breaks), 32'd1);
        check("game.warn_seen", 32'(seen_warn), 32'd1);
        check("game.rounds_left", 32'(rnd_q.size()), 32'd0);

        // Abort from OVER
        abort = 1'b1; step(); abort = 1'b0;
        check_outs("over_abort", 0, 0, 4'd0, 0, 0, 0);

        // Reset in mid-BREAK, then a fresh game
        start = 1'b1; step(); start = 1'b0;
        cyc = 0;
        while (!round_done && cyc < 1000) begin step(); cyc++; end
        check("rst.reached_break", 32'(round_done), 32'd1);
        step(); step();
        check("rst.in_break", 32'(tmr_rst_n && !tmr_en && !game_over), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst.async", 0, 0, 4'd0, 0, 0, 0);
        step();
        check_outs("rst.held", 0, 0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_outs("rst.idle", 0, 0, 4'd0, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        check_outs("rst.arm", 0, 0, 4'd1, 0, 0, 0);
        step();
        check_outs("rst.run", 1, 1, 4'd1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
